// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared USB receive constants and the bit-stuffing decision type (RX_STUFF_ERR_EN selects stuff-error reporting)
package usb_rx_pkg;
    localparam int STUFF_RUN_LEN = 6;
    localparam int DATA_W_DEF = 8;
    localparam int RUN_W = $clog2(STUFF_RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_RUN_LEN);
    typedef enum logic [1:0] {
        DEC_IDLE,
        DEC_ACCEPT,
        DEC_DROP,
        DEC_ERR
    } stuff_dec_t;
endpackage

// File: rtl/rx_unstuff_shift_if.sv
// rx_unstuff_shift_if: serial-in / byte-out bundle between decoder, unstuffer and RX controller (stuff_err present only with RX_STUFF_ERR_EN)
interface rx_unstuff_shift_if
    import usb_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              d_orig;
    logic              shift_enable;
    logic              eop_detected;
    logic              sync_clear;
    logic [DATA_W-1:0] rx_byte;
    logic              byte_valid;
    logic              bit_dropped;
    logic              align_err;
`ifdef RX_STUFF_ERR_EN
    logic              stuff_err;
`endif
    modport master (
        output d_orig, shift_enable, eop_detected, sync_clear,
`ifdef RX_STUFF_ERR_EN
        input  stuff_err,
`endif
        input  rx_byte, byte_valid, bit_dropped, align_err
    );
    modport slave (
        input  d_orig, shift_enable, eop_detected, sync_clear,
`ifdef RX_STUFF_ERR_EN
        output stuff_err,
`endif
        output rx_byte, byte_valid, bit_dropped, align_err
    );
endinterface

// File: rtl/rx_stuff_counter.sv
// rx_stuff_counter: tracks the run of consecutive ones and decides accept/drop/error per strobe (RX_STUFF_ERR_EN turns a seventh one into an error)
module rx_stuff_counter
    import usb_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       strobe,
    input  logic       d,
    input  logic       clr,
    output stuff_dec_t dec
);
    logic [RUN_W-1:0] ones_run;

    // a full run of ones means the next zero is a stuffed bit; a one there is an error or plain data
    always_comb begin
        dec = DEC_IDLE;
        if (strobe)
`ifdef RX_STUFF_ERR_EN
            dec = (ones_run != RUN_MAX) ? DEC_ACCEPT : d ? DEC_ERR : DEC_DROP;
`else
            dec = (ones_run != RUN_MAX) ? DEC_ACCEPT : d ? DEC_ACCEPT : DEC_DROP;
`endif
    end

    // run length grows on accepted ones (saturating), restarts on any zero or realignment
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ones_run <= '0;
        else if (clr)
            ones_run <= '0;
        else if (dec == DEC_ACCEPT)
            ones_run <= !d ? '0 : (ones_run == RUN_MAX) ? ones_run : ones_run + 1'b1;
        else if (dec == DEC_DROP)
            ones_run <= '0;
    end
endmodule

// File: rtl/rx_unstuff_shift.sv
// rx_unstuff_shift: removes stuffed bits and assembles LSB-first bytes, flagging partial bytes at EOP (RX_STUFF_ERR_EN adds sticky stuff_err)
module rx_unstuff_shift
    import usb_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
)(
    input  logic              clk,
    input  logic              rst,
    rx_unstuff_shift_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic              eop_q;
    logic              eop_rise;
    logic              strobe;
    stuff_dec_t        dec;

    assign eop_rise = bus.eop_detected & ~eop_q;
    assign strobe   = bus.shift_enable & ~bus.eop_detected & ~bus.sync_clear;
    assign nxt      = {bus.d_orig, sr[DATA_W-1:1]};

    rx_stuff_counter u_cnt (
        .clk    (clk),
        .rst    (rst),
        .strobe (strobe),
        .d      (bus.d_orig),
        .clr    (bus.sync_clear | eop_rise),
        .dec    (dec)
    );

    // remember the previous EOP level so only its rising edge realigns
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            eop_q <= 1'b0;
        else
            eop_q <= bus.eop_detected;
    end

    // shift accepted bits in from the top; a completed byte is published and the count wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr              <= '0;
            bit_cnt         <= '0;
            bus.rx_byte     <= '0;
            bus.byte_valid  <= 1'b0;
            bus.bit_dropped <= 1'b0;
            bus.align_err   <= 1'b0;
        end else begin
            bus.byte_valid  <= 1'b0;
            bus.bit_dropped <= (dec == DEC_DROP);
            bus.align_err   <= eop_rise & ~bus.sync_clear & (bit_cnt != '0);
            if (bus.sync_clear || eop_rise) begin
                bit_cnt <= '0;
            end else if (dec == DEC_ACCEPT) begin
                sr      <= nxt;
                bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + 1'b1;
                if (bit_cnt == LAST) begin
                    bus.rx_byte    <= nxt;
                    bus.byte_valid <= 1'b1;
                end
            end
        end
    end

`ifdef RX_STUFF_ERR_EN
    // a one after a full run is a protocol violation; hold the flag until the next packet starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.stuff_err <= 1'b0;
        else if (bus.sync_clear)
            bus.stuff_err <= 1'b0;
        else if (dec == DEC_ERR)
            bus.stuff_err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_rx_unstuff_shift.sv
// tb_rx_unstuff_shift: directed checks of byte assembly, unstuffing, EOP alignment, realignment and reset (RX_STUFF_ERR_EN selects the stuff-error branch)
module tb_rx_unstuff_shift;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passed = 0;
    int   total = 0;
    int   nbv = 0;
    int   nbd = 0;
    int   nal = 0;

    rx_unstuff_shift_if #(.DATA_W(8)) bus ();

    rx_unstuff_shift #(.DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tally();
        nbv += int'(bus.byte_valid);
        nbd += int'(bus.bit_dropped);
        nal += int'(bus.align_err);
    endtask

    task automatic clr_cnt();
        nbv = 0;
        nbd = 0;
        nal = 0;
    endtask

    task automatic send(input logic b);
        bus.d_orig       = b;
        bus.shift_enable = 1'b1;
        @(negedge clk);
        bus.shift_enable = 1'b0;
        tally();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            tally();
        end
    endtask

    task automatic sync();
        bus.sync_clear = 1'b1;
        @(negedge clk);
        bus.sync_clear = 1'b0;
        tally();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send(v[i]);
    endtask

    initial begin
        bus.d_orig       = 1'b0;
        bus.shift_enable = 1'b0;
        bus.eop_detected = 1'b0;
        bus.sync_clear   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_rx_byte", 32'(bus.rx_byte), 32'h0);
        chk("reset_pulses", {29'd0, bus.byte_valid, bus.bit_dropped, bus.align_err}, 32'h0);
        rst = 1'b0;
        idle(1);

        // bits 1,0,1,1,0,0,1,0 -> 0x4D
        clr_cnt();
        sync();
        send(1); send(0); send(1); send(1); send(0); send(0); send(1);
        chk("basic_no_early_valid", 32'(nbv), 32'd0);
        send(0);
        chk("basic_valid", 32'(bus.byte_valid), 32'd1);
        chk("basic_byte", 32'(bus.rx_byte), 32'h4D);
        idle(2);
        chk("basic_one_valid", 32'(nbv), 32'd1);
        chk("basic_hold", 32'(bus.rx_byte), 32'h4D);

        // six ones, stuffed zero, two ones -> 0xFF
        clr_cnt();
        repeat (6) send(1);
        send(0);
        chk("stuff_drop_pulse", 32'(bus.bit_dropped), 32'd1);
        send(1);
        chk("stuff_not_yet", 32'(nbv), 32'd0);
        send(1);
        chk("stuff_valid", 32'(bus.byte_valid), 32'd1);
        chk("stuff_byte", 32'(bus.rx_byte), 32'hFF);
        chk("stuff_drop_once", 32'(nbd), 32'd1);

        // realignment coincident with a strobe mid-byte
        clr_cnt();
        sync();
        send(1); send(1); send(1);
        bus.sync_clear = 1'b1;
        send(1);
        bus.sync_clear = 1'b0;
        chk("sync_no_pulse", {29'd0, bus.byte_valid, bus.bit_dropped, bus.align_err}, 32'h0);
        send_byte(8'h0A);
        chk("sync_byte", 32'(bus.rx_byte), 32'h0A);
        chk("sync_one_valid", 32'(nbv), 32'd1);

        // partial byte then EOP with strobes
        clr_cnt();
        send(1); send(0); send(1);
        bus.eop_detected = 1'b1;
        send(1);
        chk("eop_align_err", 32'(bus.align_err), 32'd1);
        send(1); send(1); send(0);
        bus.eop_detected = 1'b0;
        idle(2);
        chk("eop_align_once", 32'(nal), 32'd1);
        chk("eop_no_valid", 32'(nbv), 32'd0);
        chk("eop_byte_kept", 32'(bus.rx_byte), 32'h0A);
        send_byte(8'h0F);
        chk("eop_realigned", 32'(bus.rx_byte), 32'h0F);
        chk("eop_realigned_valid", 32'(nbv), 32'd1);

        // a one after six ones
        clr_cnt();
        sync();
        repeat (7) send(1);
`ifdef RX_STUFF_ERR_EN
        chk("err_set", 32'(bus.stuff_err), 32'd1);
        send(1);
        chk("err_sticky", 32'(bus.stuff_err), 32'd1);
        chk("err_no_valid", 32'(nbv), 32'd0);
        sync();
        chk("err_cleared", 32'(bus.stuff_err), 32'd0);
`else
        chk("sat_no_drop", 32'(nbd), 32'd0);
        chk("sat_no_valid", 32'(nbv), 32'd0);
        send(1);
        chk("sat_valid", 32'(bus.byte_valid), 32'd1);
        chk("sat_byte", 32'(bus.rx_byte), 32'hFF);
`endif

        // asynchronous reset after five bits
        sync();
        send(1); send(0); send(1); send(1); send(0);
        #2 rst = 1'b1;
        #1;
        chk("arst_rx_byte", 32'(bus.rx_byte), 32'h0);
        chk("arst_pulses", {29'd0, bus.byte_valid, bus.bit_dropped, bus.align_err}, 32'h0);
`ifdef RX_STUFF_ERR_EN
        chk("arst_stuff_err", 32'(bus.stuff_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        clr_cnt();
        idle(4);
        chk("arst_no_pulses", 32'(nbv + nbd + nal), 32'd0);
        send_byte(8'hCC);
        chk("arst_fresh_byte", 32'(bus.rx_byte), 32'hCC);
        chk("arst_one_valid", 32'(nbv), 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
